unidade_controle: RTL



---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/contador_passos.sv | 34 +++
 rtl/unidade_controle.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, step encoding and instruction-field positions for the bus processor control unit.
// Optional mvnz support is enabled by defining CTRL_MVNZ_EN.
package ctrl_pkg;

    localparam int unsigned IR_W   = 9;
    localparam int unsigned STEP_W = 2;

    localparam int unsigned OP_HI = 8;
    localparam int unsigned OP_LO = 6;
    localparam int unsigned RX_HI = 5;
    localparam int unsigned RX_LO = 3;
    localparam int unsigned RY_HI = 2;
    localparam int unsigned RY_LO = 0;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    typedef enum logic [STEP_W-1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/contador_passos.sv
// Two-bit instruction time-step counter: advances on en_i, synchronous clear on clr_i (Done).
module contador_passos
    import ctrl_pkg::*;
(
    input  logic  Clock,
    input  logic  Reset,
    input  logic  en_i,
    input  logic  clr_i,
    output step_t step_o
);

    step_t step_q;
    step_t step_d;

    always_comb begin
        step_d = step_q;
        if (clr_i) begin
            step_d = T0;
        end else if (en_i) begin
            step_d = step_t'(2'(step_q + 2'd1));
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/unidade_controle.sv
// Control FSM for the 16-bit bus processor: fetches a 9-bit instruction and sequences bus selects and
// register-load enables over T0..T3. Define CTRL_MVNZ_EN to enable the conditional move (opcode 100).
module unidade_controle
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Gnz,
    output logic [7:0]        selectR,
    output logic              selectG,
    output logic              selectDin,
    output logic [NREGS-1:0]  Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              IRin,
    output logic              Done,
    output logic [IR_W-1:0]   IR
);

    step_t           step;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_d;
    logic [2:0]      opcode;
    logic [2:0]      rx;
    logic [2:0]      ry;
    logic [2:0]      sel_idx;
    logic            rin_en;

    assign opcode = ir_q[OP_HI:OP_LO];
    assign rx     = ir_q[RX_HI:RX_LO];
    assign ry     = ir_q[RY_HI:RY_LO];

    contador_passos u_passos (
        .Clock  (Clock),
        .Reset  (Reset),
        .en_i   ((step != T0) || Run),
        .clr_i  (Done),
        .step_o (step)
    );

    // Instruction register loads only on the fetch step.
    always_comb begin
        ir_d = ir_q;
        if (IRin) begin
            ir_d = DIN[IR_W-1:0];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    // Per-step decode; anything not explicitly sourced stays at zero.
    always_comb begin
        sel_idx   = 3'd0;
        selectG   = 1'b0;
        selectDin = 1'b0;
        rin_en    = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        IRin      = 1'b0;
        Done      = 1'b0;
        unique case (step)
            T0: IRin = Run;
            T1: begin
                if (is_alu_op(opcode)) begin
                    sel_idx = rx;
                    Ain     = 1'b1;
                end else begin
                    Done = 1'b1;
                    if (opcode == OP_MV) begin
                        sel_idx = ry;
                        rin_en  = 1'b1;
                    end else if (opcode == OP_MVI) begin
                        selectDin = 1'b1;
                        rin_en    = 1'b1;
                    end
`ifdef CTRL_MVNZ_EN
                    else if ((opcode == OP_MVNZ) && Gnz) begin
                        sel_idx = ry;
                        rin_en  = 1'b1;
                    end
`endif
                end
            end
            T2: begin
                if (is_alu_op(opcode)) begin
                    sel_idx = ry;
                    Gin     = 1'b1;
                    AddSub  = (opcode == OP_SUB);
                end
            end
            T3: begin
                Done = 1'b1;
                if (is_alu_op(opcode)) begin
                    selectG = 1'b1;
                    rin_en  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign selectR = 8'(sel_idx);
    assign Rin     = rin_en ? (NREGS'(1) << rx) : '0;
    assign IR      = ir_q;

`ifdef CTRL_MVNZ_EN
    logic unused_din_c;
    assign unused_din_c = ^DIN[DATA_W-1:IR_W];
`else
    logic unused_din_c;
    assign unused_din_c = ^{DIN[DATA_W-1:IR_W], Gnz};
`endif

endmodule
